fractal_sync_rsp_drv: RTL and testbench

- Downstream link driver for one output direction of a fractal-sync node. It consumes one response FIFO interface (empty/element/pop) of the TX datapath and drives single-cycle wake responses to the child node.
- Credit-based flow control protects the child's RX FIFO. A programmable minimum gap spaces consecutive wake pulses.
- One instance per direction pair: EN and WS.

---
 rtl/fractal_sync_rsp_drv.sv | 150 +++++++++++++++
 tb/tb_fractal_sync_rsp_drv.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rsp_drv.sv
// Fractal-sync downstream response driver: pops the TX response FIFO and drives one-cycle wake pulses, credit- and gap-limited.
// Pop at t, wake at t+1; stalls with pop_o=0 when out of credits. Optional counters: FRACTAL_SYNC_RSP_DRV_STATS_EN.

package fractal_sync_rsp_drv_pkg;
  typedef struct packed {
    logic       wake;
    logic [1:0] dst;
    logic       error;
  } fsync_rsp_t;
endpackage

module fractal_sync_rsp_drv #(
  parameter type         fsync_rsp_t = fractal_sync_rsp_drv_pkg::fsync_rsp_t,
  parameter int unsigned CREDITS     = 1,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             empty_i,
  input  fsync_rsp_t       rsp_i,
  output logic             pop_o,
  output fsync_rsp_t       rsp_o,
  input  logic             credit_i,
  output logic             credit_error_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] sent_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned CRED_W = $clog2(CREDITS + 1);
  localparam int unsigned GAP_W  = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  fsync_rsp_t        rsp_q, rsp_d;
  logic              credit_err_q, credit_err_d;
  logic              can_issue;
  logic              fire;

  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    gap_d        = gap_q;
    rsp_d        = '0;
    credit_err_d = 1'b0;

    can_issue = (state_q == IDLE) || ((state_q == SEND) && (GAP_CYCLES == 0));
    fire      = !empty_i && (credits_q != '0) && can_issue;

    if (fire) begin
      rsp_d      = rsp_i;
      rsp_d.wake = 1'b1;
    end

    // The IDLE cycle that pops the next entry is itself the last idle slot on rsp_o,
    // so GAP only needs to cover GAP_CYCLES-1 cycles to give a period of GAP_CYCLES+1.
    case (state_q)
      IDLE: begin
        if (fire) state_d = SEND;
      end
      SEND: begin
        if (fire) begin
          state_d = SEND;
        end else if (GAP_CYCLES > 1) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fire && !credit_i) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!fire && credit_i) begin
      if (credits_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      credits_q    <= CRED_MAX;
      gap_q        <= '0;
      rsp_q        <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      gap_q        <= gap_d;
      rsp_q        <= rsp_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign pop_o          = fire;
  assign rsp_o          = rsp_q;
  assign credit_error_o = credit_err_q;
  assign busy_o         = (state_q != IDLE) || (credits_q != CRED_MAX);

`ifdef FRACTAL_SYNC_RSP_DRV_STATS_EN
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (rsp_q.wake) begin
      sent_cnt_d = sent_cnt_q + CNT_W'(1);
      if (rsp_q.error) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign sent_cnt_o = sent_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`else
  assign sent_cnt_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_rsp_drv.sv
// Bench for fractal_sync_rsp_drv: dut0 (CREDITS=2, GAP=0) and dut1 (CREDITS=4, GAP=3) with a scoreboard of pop/wake cycles.
module tb_fractal_sync_rsp_drv;

  typedef fractal_sync_rsp_drv_pkg::fsync_rsp_t rsp_t;
  typedef struct packed {
    int   cyc;
    rsp_t rsp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO models (ring buffers, combinational head)
  rsp_t       fifo_mem [2][16];
  logic [7:0] wr_ptr [2];
  logic [7:0] rd_ptr [2];
  logic       pop_seen [2];

  logic        empty0, empty1, pop0, pop1, credit0, credit1, cerr0, cerr1, busy0, busy1;
  rsp_t        rsp_in0, rsp_in1, rsp_out0, rsp_out1;
  logic [15:0] sent0, sent1, errc0, errc1;

  assign empty0  = (wr_ptr[0] == rd_ptr[0]);
  assign empty1  = (wr_ptr[1] == rd_ptr[1]);
  assign rsp_in0 = fifo_mem[0][rd_ptr[0][3:0]];
  assign rsp_in1 = fifo_mem[1][rd_ptr[1][3:0]];

  fractal_sync_rsp_drv #(.CREDITS(2), .GAP_CYCLES(0), .CNT_W(16)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .empty_i(empty0), .rsp_i(rsp_in0), .pop_o(pop0),
    .rsp_o(rsp_out0), .credit_i(credit0), .credit_error_o(cerr0), .busy_o(busy0),
    .sent_cnt_o(sent0), .err_cnt_o(errc0)
  );

  fractal_sync_rsp_drv #(.CREDITS(4), .GAP_CYCLES(3), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .empty_i(empty1), .rsp_i(rsp_in1), .pop_o(pop1),
    .rsp_o(rsp_out1), .credit_i(credit1), .credit_error_o(cerr1), .busy_o(busy1),
    .sent_cnt_o(sent1), .err_cnt_o(errc1)
  );

  always @(negedge clk) begin
    pop_seen[0] = pop0;
    pop_seen[1] = pop1;
  end

  always @(posedge clk) begin
    if (pop_seen[0]) rd_ptr[0] <= rd_ptr[0] + 8'd1;
    if (pop_seen[1]) rd_ptr[1] <= rd_ptr[1] + 8'd1;
  end

  int   exp_pop [2][$];
  exp_t exp_rsp [2][$];

  function automatic rsp_t mk(input logic w, input logic [1:0] d, input logic e);
    rsp_t r;
    r.wake  = w;
    r.dst   = d;
    r.error = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic mon(input int d, input logic p, input rsp_t r);
    int   ec;
    exp_t e;
    if (p) begin
      checks++;
      if (exp_pop[d].size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected[%0d]: pop_o=1 at cycle %0d, none expected", d, cyc);
      end else begin
        ec = exp_pop[d].pop_front();
        if (ec != cyc) begin
          errors++;
          $display("FAIL pop_cycle[%0d]: pop_o at cycle %0d expected cycle %0d", d, cyc, ec);
        end
      end
    end
    if (r.wake) begin
      checks++;
      if (exp_rsp[d].size() == 0) begin
        errors++;
        $display("FAIL wake_unexpected[%0d]: rsp_o=%0h at cycle %0d, none expected", d, r, cyc);
      end else begin
        e = exp_rsp[d].pop_front();
        if (e.cyc != cyc || e.rsp != r) begin
          errors++;
          $display("FAIL wake[%0d]: rsp_o=%0h at cycle %0d expected %0h at cycle %0d",
                   d, r, cyc, e.rsp, e.cyc);
        end
      end
    end else begin
      checks++;
      if (r != '0) begin
        errors++;
        $display("FAIL rsp_idle[%0d]: rsp_o=%0h without wake at cycle %0d expected 0", d, r, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, pop0, rsp_out0);
    mon(1, pop1, rsp_out1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input rsp_t r);
    fifo_mem[d][wr_ptr[d][3:0]] = r;
    wr_ptr[d] = wr_ptr[d] + 8'd1;
  endtask

  task automatic expect_send(input int d, input int pop_cyc, input rsp_t r);
    exp_t e;
    e.cyc = pop_cyc + 1;
    e.rsp = r;
    exp_pop[d].push_back(pop_cyc);
    exp_rsp[d].push_back(e);
  endtask

  int   c, t, u, v, g, r;
  rsp_t el;

  initial begin
    credit0 = 1'b0;
    credit1 = 1'b0;
    wr_ptr[0] = '0; wr_ptr[1] = '0;
    rd_ptr[0] = '0; rd_ptr[1] = '0;
    #1 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rsp0",  32'(rsp_out0), 32'h0);
    chk("rst_pop0",  32'(pop0),     32'h0);
    chk("rst_cerr0", 32'(cerr0),    32'h0);
    chk("rst_busy0", 32'(busy0),    32'h0);
    chk("rst_sent0", 32'(sent0),    32'h0);
    chk("rst_errc0", 32'(errc0),    32'h0);
    chk("rst_rsp1",  32'(rsp_out1), 32'h0);
    chk("rst_pop1",  32'(pop1),     32'h0);
    chk("rst_cerr1", 32'(cerr1),    32'h0);
    chk("rst_busy1", 32'(busy1),    32'h0);
    chk("rst_sent1", 32'(sent1),    32'h0);
    chk("rst_errc1", 32'(errc1),    32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Basic single response, busy until the credit returns
    tick(); c = cyc;
    el = mk(1'b1, 2'b01, 1'b0);
    push(0, el); expect_send(0, c, el);
    @(negedge clk) chk("t1_pop", 32'(pop0), 32'h1);
    tick(); tick();
    credit0 = 1'b1;
    @(negedge clk) chk("t1_busy_hold", 32'(busy0), 32'h1);
    tick();
    credit0 = 1'b0;
    @(negedge clk) chk("t1_busy_clear", 32'(busy0), 32'h0);

    // Back-to-back then credit stall
    tick(); t = cyc;
    push(0, mk(1'b1, 2'b10, 1'b0)); expect_send(0, t,     mk(1'b1, 2'b10, 1'b0));
    push(0, mk(1'b1, 2'b11, 1'b1)); expect_send(0, t + 1, mk(1'b1, 2'b11, 1'b1));
    push(0, mk(1'b1, 2'b00, 1'b0));
    repeat (5) tick();
    u = cyc;
    credit0 = 1'b1;
    expect_send(0, u + 1, mk(1'b1, 2'b00, 1'b0));
    @(negedge clk) chk("t2_stall_pop", 32'(pop0), 32'h0);
    tick();
    credit0 = 1'b0;
    tick();
    tick(); credit0 = 1'b1;

    // Simultaneous fire and credit at credits==1: second entry still fires next cycle
    tick();
    push(0, mk(1'b1, 2'b01, 1'b1)); expect_send(0, u + 4, mk(1'b1, 2'b01, 1'b1));
    push(0, mk(1'b1, 2'b10, 1'b1)); expect_send(0, u + 5, mk(1'b1, 2'b10, 1'b1));
    tick(); credit0 = 1'b0;
    tick();
    tick(); credit0 = 1'b1;
    tick();
    tick(); credit0 = 1'b0;
    @(negedge clk) chk("t4_busy_refilled", 32'(busy0), 32'h0);

    // Credit returned at full count
    tick(); v = cyc;
    credit0 = 1'b1;
    @(negedge clk) chk("cerr_before", 32'(cerr0), 32'h0);
    tick(); credit0 = 1'b0;
    @(negedge clk) begin
      chk("cerr_pulse", 32'(cerr0), 32'h1);
      chk("cerr_sat_busy", 32'(busy0), 32'h0);
    end
    tick();
    @(negedge clk) begin
      chk("cerr_after", 32'(cerr0), 32'h0);
      chk("cerr_sat_busy2", 32'(busy0), 32'h0);
    end

    // Gap enforcement on dut1: pulses 4 cycles apart
    tick(); g = cyc;
    for (int i = 0; i < 4; i++) begin
      el = mk(1'b1, 2'(i), 1'(i % 2));
      push(1, el); expect_send(1, g + 4 * i, el);
    end
    repeat (15) tick();
    credit1 = 1'b1;
    repeat (4) tick();
    credit1 = 1'b0;
    @(negedge clk) chk("gap_busy_refilled", 32'(busy1), 32'h0);

    // Reset the cycle after a pop: popped entry is dropped
    tick(); r = cyc;
    push(0, mk(1'b1, 2'b11, 1'b0)); exp_pop[0].push_back(r);
    tick(); rst_n = 1'b0;
    @(negedge clk) begin
      chk("mid_rst_rsp",  32'(rsp_out0), 32'h0);
      chk("mid_rst_pop",  32'(pop0),     32'h0);
      chk("mid_rst_busy", 32'(busy0),    32'h0);
      chk("mid_rst_cerr", 32'(cerr0),    32'h0);
    end
    tick(); rst_n = 1'b1;
    @(negedge clk) chk("post_rst_busy", 32'(busy0), 32'h0);

    // Five sends, two with error=1
    for (int i = 0; i < 5; i++) begin
      tick(); c = cyc;
      el = mk(1'b1, 2'(i), (i == 1 || i == 3) ? 1'b1 : 1'b0);
      push(0, el); expect_send(0, c, el);
      tick(); tick();
      credit0 = 1'b1;
      tick();
      credit0 = 1'b0;
    end
    tick();
`ifdef FRACTAL_SYNC_RSP_DRV_STATS_EN
    @(negedge clk) begin
      chk("stats_sent", 32'(sent0), 32'd5);
      chk("stats_err",  32'(errc0), 32'd2);
    end
`else
    @(negedge clk) begin
      chk("stats_sent", 32'(sent0), 32'd0);
      chk("stats_err",  32'(errc0), 32'd0);
    end
`endif
    chk("stats_busy", 32'(busy0), 32'h0);
    repeat (3) tick();

    chk("sb_pop_left0",  32'(exp_pop[0].size()), 32'd0);
    chk("sb_wake_left0", 32'(exp_rsp[0].size()), 32'd0);
    chk("sb_pop_left1",  32'(exp_pop[1].size()), 32'd0);
    chk("sb_wake_left1", 32'(exp_rsp[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
